// File: rtl/run_detect_pkg.sv
// run_detect_pkg: FSM state encoding, default word width and requester ids for run_detect_sched
package run_detect_pkg;
  localparam int W_DEF = 8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/run_detector.sv
// run_detector: bit-serial run tracker (clk, reset, clr, en, in -> hit while a run of 4+ equal bits is present)
module run_detector (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic in,
  output logic hit
);
  logic val;
  logic [2:0] len;
  assign hit = len == 3'd4;
  always_ff @(posedge clk)
    if (reset || clr) begin
      val <= 1'b0;
      len <= 3'd0;
    end else if (en) begin
      val <= in;
      len <= (len == 3'd0 || in != val) ? 3'd1 : hit ? 3'd4 : len + 3'd1;
    end
endmodule

// File: rtl/run_detect_sched.sv
// run_detect_sched: two-requester scheduler counting 4-bit equal runs per word (clk, reset, req0/1 valid/data/ready, res valid/ready/id/hits; RUN_DETECT_SCHED_RR_EN selects round-robin over fixed priority)
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_id,
  output logic [CW-1:0] res_hits
);
  localparam int IW = $clog2(W);
  logic [1:0] state;
  logic [W-1:0] word;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic id, hit, gnt1, take;
`ifdef RUN_DETECT_SCHED_RR_EN
  logic last;
  always_ff @(posedge clk)
    if (reset) last <= REQ1;
    else if (take) last <= gnt1;
  assign gnt1 = req1_valid && (!req0_valid || last == REQ0);
`else
  assign gnt1 = req1_valid && !req0_valid;
`endif
  assign take = state == IDLE && !reset && (req0_valid || req1_valid);
  assign req0_ready = take && !gnt1;
  assign req1_ready = take && gnt1;
  assign res_valid = state == DONE && !reset;
  assign res_id = res_valid && id;
  assign res_hits = res_valid ? cnt + CW'(hit) : '0;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      id <= REQ0;
      word <= '0;
      idx <= '0;
      cnt <= '0;
    end else if (take) begin
      state <= SHIFT;
      id <= gnt1;
      word <= gnt1 ? req1_data : req0_data;
      idx <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      word <= word >> 1;
      idx <= idx + IW'(1);
      cnt <= cnt + CW'(hit);
      state <= idx == IW'(W - 1) ? DONE : SHIFT;
    end else if (res_valid && res_ready) state <= IDLE;
  run_detector u_det (
    .clk  (clk),
    .reset(reset),
    .clr  (take),
    .en   (state == SHIFT),
    .in   (word[0]),
    .hit  (hit)
  );
endmodule

// File: tb/tb_run_detect_sched.sv
// tb_run_detect_sched: directed and random checks of run_detect_sched against a word-level reference model
module tb_run_detect_sched;
  localparam int W = 8;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, res_valid, res_id;
  logic [CW-1:0] res_hits;
  int n_checks = 0;
  int n_fail = 0;
  bit saw_r1 = 1'b0;
  bit m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0;
  int m_wait = 0, m_hits = 0;
  always #5 clk = ~clk;
  run_detect_sched #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_hits  (res_hits)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  function automatic int hits_of(input logic [W-1:0] w);
    int h = 0;
    for (int i = 3; i < W; i++) if (w[i-:4] == 4'h0 || w[i-:4] == 4'hF) h++;
    return h;
  endfunction
  always @(negedge clk) begin
    bit ev, e0, e1;
    if (req1_ready) saw_r1 = 1'b1;
    if (reset) begin
      chk("rst_valid", res_valid, 0);
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_id", res_id, 0);
      chk("rst_hits", res_hits, 0);
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      ev = m_busy && m_wait == 0;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!m_busy && (req0_valid || req1_valid)) begin
`ifdef RUN_DETECT_SCHED_RR_EN
        e1 = req1_valid && (!req0_valid || !m_last);
`else
        e1 = req1_valid && !req0_valid;
`endif
        e0 = !e1;
      end
      chk("m_valid", res_valid, ev);
      chk("m_rdy0", req0_ready, e0);
      chk("m_rdy1", req1_ready, e1);
      if (ev) begin
        chk("m_id", res_id, m_id);
        chk("m_hits", res_hits, m_hits);
      end
      if (e0 || e1) begin
        m_busy = 1'b1;
        m_wait = W;
        m_id = e1;
        m_last = e1;
        m_hits = hits_of(e1 ? req1_data : req0_data);
      end else if (ev && res_ready) m_busy = 1'b0;
      else if (m_busy && m_wait > 0) m_wait--;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask
  task automatic send(input bit r, input logic [W-1:0] d, output int lat, output int id, output int h);
    tick();
    if (r) begin
      req1_valid = 1'b1;
      req1_data = d;
    end else begin
      req0_valid = 1'b1;
      req0_data = d;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_res(lat);
    lat++;
    id = res_id;
    h = res_hits;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int lat, id, h;
    bit seen;
    chk("model_0F", hits_of(8'h0F), 2);
    chk("model_00", hits_of(8'h00), 5);
    chk("model_AA", hits_of(8'hAA), 0);
    chk("model_FF", hits_of(8'hFF), 5);
    repeat (2) tick();
    chk("reset_valid", res_valid, 0);
    reset = 1'b0;
    send(0, 8'h0F, lat, id, h);
    chk("s1_lat", lat, 9);
    chk("s1_id", id, 0);
    chk("s1_hits", h, 2);
    send(1, 8'h00, lat, id, h);
    chk("s2_id", id, 1);
    chk("s2_hits", h, 5);
    send(1, 8'hAA, lat, id, h);
    chk("s2b_hits", h, 0);
    tick();
    saw_r1 = 1'b0;
    req0_valid = 1'b1;
    req0_data = 8'h0F;
    req1_valid = 1'b1;
    req1_data = 8'hF0;
    for (int k = 0; k < 4; k++) begin
      wait_res(lat);
`ifdef RUN_DETECT_SCHED_RR_EN
      chk("s3_id", res_id, k % 2);
`else
      chk("s3_id", res_id, 0);
`endif
      chk("s3_hits", res_hits, 2);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
`ifndef RUN_DETECT_SCHED_RR_EN
    chk("s3_no_r1", saw_r1, 0);
`endif
    res_ready = 1'b0;
    tick();
    req0_valid = 1'b1;
    req0_data = 8'h33;
    req1_valid = 1'b1;
    req1_data = 8'h0F;
    tick();
    req0_valid = 1'b0;
    wait_res(lat);
    chk("s4_id", res_id, 0);
    chk("s4_hits", res_hits, 0);
    repeat (5) begin
      tick();
      chk("s4_hold_valid", res_valid, 1);
      chk("s4_hold_id", res_id, 0);
      chk("s4_hold_hits", res_hits, 0);
      chk("s4_hold_rdy1", req1_ready, 0);
    end
    res_ready = 1'b1;
    #1;
    chk("s4_hs_rdy1", req1_ready, 0);
    tick();
    chk("s4_grant", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    wait_res(lat);
    chk("s4_next_id", res_id, 1);
    chk("s4_next_hits", res_hits, 2);
    tick();
    req0_valid = 1'b1;
    req0_data = 8'h00;
    tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("s5_no_result", seen, 0);
    send(0, 8'hFF, lat, id, h);
    chk("s5_lat", lat, 9);
    chk("s5_hits", h, 5);
    for (int c = 0; c < 600; c++) begin
      tick();
      reset = $urandom_range(63) == 0;
      req0_valid = $urandom_range(1) == 1;
      req1_valid = $urandom_range(1) == 1;
      req0_data = W'($urandom);
      req1_data = W'($urandom);
      res_ready = $urandom_range(3) != 0;
    end
    tick();
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/run_detect_sched.md
RUN_DETECT_SCHED -- requirements
Module: run_detect_sched

Interface
REQ-001 SHALL have parameter W, default 8, meaning the word width in bits (legal range 4..16).
REQ-002 SHALL have parameter CW, default $clog2(W+1), meaning the width of the hit count.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester has a word.
REQ-006 SHALL have ports req0_data / req1_data  input  W  word to scan.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  word accepted this cycle.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer takes the result.
REQ-010 SHALL have port res_id  output  1  requester index of the result.
REQ-011 SHALL have port res_hits  output  CW  run-detect hit count of the word.

Function
REQ-012 SHALL implement states IDLE, SHIFT and DONE.
REQ-013 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally in the same cycle, latch word and id, clear the bit index, hit counter and detector, and go to SHIFT.
REQ-014 SHALL never assert reqN_ready outside IDLE, and never for more than one requester per cycle.
REQ-015 SHIFT: SHALL feed one latched bit per cycle, LSB first, into the run detector; after bit W-1 it SHALL go to DONE.
REQ-016 Hit rule: bit position i (3<=i<=W-1) SHALL count as one hit iff bits i-3..i of the word are all equal; runs longer than 4 count once per position.
REQ-017 The detector SHALL restart for every word; no history carries across words.
REQ-018 Latency: for a word accepted in cycle t, res_valid SHALL first be high in cycle t+W+1.
REQ-019 DONE: res_valid SHALL be high, and res_id/res_hits SHALL be held stable, until the cycle where res_ready=1; the FSM SHALL then go to IDLE.
REQ-020 After a result handshake in cycle u, a new word SHALL be acceptable in cycle u+1.
REQ-021 res_hits SHALL be unsigned; its maximum value W-3 always fits in CW bits, so no saturation logic is needed.
REQ-022 Input changes on a requester that is not granted SHALL have no effect.

Reset
REQ-023 While reset=1: state SHALL be IDLE; res_valid, res_id, res_hits, req0_ready and req1_ready SHALL all be 0; the round-robin pointer SHALL favour req0.
REQ-024 Reset during SHIFT or DONE SHALL discard the word in flight; no result for it SHALL ever appear.

Configuration
REQ-025 With macro RUN_DETECT_SCHED_RR_EN defined, arbitration SHALL be round-robin: when both requesters are valid, the one not granted last SHALL win; with a single requester valid, that requester SHALL win.
REQ-026 With RUN_DETECT_SCHED_RR_EN undefined, arbitration SHALL be fixed priority, req0 over req1, and no pointer register SHALL exist.

Structure
REQ-027 Package run_detect_pkg SHALL hold the state encoding (IDLE=0, SHIFT=1, DONE=2), the default W, and the requester id constants REQ0=0 and REQ1=1.
REQ-028 The run detector SHALL be a sub-module, run_detector, with:
- inputs: clk, reset, clr, en, in;
- output: hit;
- states: 0-run lengths 1-4, 1-run lengths 1-4, and an empty state;
- hit asserted while a run of 4 or more is present, updated only when en=1.

Verification
REQ-029 req0 sends 0x0F, res_ready=1 -> res_valid at t+9, res_id=0, res_hits=2.
REQ-030 req1 sends 0x00 -> res_hits=5; a following 0xAA -> res_hits=0.
REQ-031 Both requesters valid continuously with 0x0F and 0xF0, RR_EN defined -> ids alternate 0,1,0,1; with the macro undefined -> id always 0, req1_ready never high.
REQ-032 res_ready held low for 5 cycles in DONE -> res_valid, res_id and res_hits stable; no new grant until the handshake cycle; a grant follows in the next cycle.
REQ-033 Reset pulsed for one cycle mid-SHIFT on a 0x00 word -> no result appears; the next word, 0xFF, gives res_hits=5.
